// File: rtl/skew_rd_control_pkg.sv
// Shared types and helpers for the skewed read sequencer.
// Holds the FSM state enum, the step-counter width rule and the per-bank lag rule.
package skew_rd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Wide enough to count past WR_LATENCY + max num_rows without overflow.
  function automatic int step_width(input int wr_latency, input int addr_width);
    return $clog2(wr_latency + (1 << addr_width)) + 1;
  endfunction

  function automatic int lag_of(input int lane, input int lanes, input logic reverse);
    return reverse ? (lanes - 1 - lane) : lane;
  endfunction

endpackage

// File: rtl/skew_rd_control_if.sv
// Bus bundle between the start/stall source and the skewed read sequencer.
// The reverse signal exists only when SKEW_RD_CONTROL_REVERSE_EN is defined.
interface skew_rd_control_if #(
  parameter int WIDTH_HEIGHT = 16,
  parameter int ADDR_WIDTH   = 8
);
  import skew_rd_pkg::*;

  // Handshake: active is a start request with no ready; it is taken only when
  // busy is low (idle or the done cycle) and dropped otherwise. stall freezes
  // the step in flight for every cycle it is high; done pulses once per start.
  logic                               active;
  logic [ADDR_WIDTH-1:0]              base_addr;
  logic [ADDR_WIDTH-1:0]              num_rows;
  logic                               stall;
`ifdef SKEW_RD_CONTROL_REVERSE_EN
  logic                               reverse;
`endif
  logic [WIDTH_HEIGHT-1:0]            rd_en;
  logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] rd_addr;
  logic                               wr_active;
  logic                               busy;
  logic                               done;

`ifdef SKEW_RD_CONTROL_REVERSE_EN
  modport master (output active, base_addr, num_rows, stall, reverse,
                  input  rd_en, rd_addr, wr_active, busy, done);
  modport slave  (input  active, base_addr, num_rows, stall, reverse,
                  output rd_en, rd_addr, wr_active, busy, done);
`else
  modport master (output active, base_addr, num_rows, stall,
                  input  rd_en, rd_addr, wr_active, busy, done);
  modport slave  (input  active, base_addr, num_rows, stall,
                  output rd_en, rd_addr, wr_active, busy, done);
`endif

endinterface

// File: rtl/skew_rd_control_lane_gen.sv
// One bank's read lane: registers rd_en/rd_addr for the step being issued.
// The address holds its last value whenever the lane is not enabled.
module rd_lane_gen
  import skew_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int STEP_W     = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  step_valid,
  input  logic                  stall,
  input  logic [STEP_W-1:0]     t,
  input  logic [STEP_W-1:0]     lag,
  input  logic [ADDR_WIDTH-1:0] num_rows,
  input  logic [ADDR_WIDTH-1:0] base,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr
);

  logic [STEP_W-1:0] rows_ext;
  logic [STEP_W-1:0] rel;
  logic              hit;

  always_comb begin
    rows_ext = STEP_W'(num_rows);
    rel      = t - lag;
    hit      = (t >= lag) && (rel < rows_ext);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else if (step_valid && !stall) begin
      rd_en <= hit;
      if (hit) rd_addr <= base + rel[ADDR_WIDTH-1:0];
    end else begin
      rd_en <= 1'b0;
    end
  end

endmodule

// File: rtl/skew_rd_control.sv
// Skewed read sequencer: bank i reads num_rows words starting lag(i) steps after bank 0.
// Define SKEW_RD_CONTROL_REVERSE_EN to add a latched reverse input that flips the lag order.
module skew_rd_control
  import skew_rd_pkg::*;
#(
  parameter int WIDTH_HEIGHT = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int WR_LATENCY   = 17
) (
  input  logic               clk,
  input  logic               reset,
  skew_rd_control_if.slave   bus,
  output state_t             fsm_state
);

  localparam int                STEP_W   = step_width(WR_LATENCY, ADDR_WIDTH);
  localparam logic [STEP_W-1:0] WR_LAT_T = STEP_W'(WR_LATENCY);

  state_t                             state;
  logic [STEP_W-1:0]                  t_q;
  logic [STEP_W-1:0]                  step_t;
  logic [STEP_W-1:0]                  last_t;
  logic [STEP_W-1:0]                  rows_cfg_t;
  logic [ADDR_WIDTH-1:0]              base_q;
  logic [ADDR_WIDTH-1:0]              rows_q;
  logic [ADDR_WIDTH-1:0]              base_cfg;
  logic [ADDR_WIDTH-1:0]              rows_cfg;
  logic                               accept;
  logic                               start;
  logic                               step_valid;
  logic                               lane_stall;
  logic                               emit;
  logic                               wr_window;
  logic                               rev_cfg;
  logic                               wr_active_q;
  logic                               busy_q;
  logic                               done_q;
  logic [WIDTH_HEIGHT-1:0]            rd_en_w;
  logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] rd_addr_w;
`ifdef SKEW_RD_CONTROL_REVERSE_EN
  logic                               reverse_q;
`endif

  // t_q is the next step to issue; a start issues step 0 on the accepting edge.
  always_comb begin
    accept     = (state != RUN) && bus.active;
    start      = accept && (bus.num_rows != '0);
    base_cfg   = start ? bus.base_addr : base_q;
    rows_cfg   = start ? bus.num_rows  : rows_q;
`ifdef SKEW_RD_CONTROL_REVERSE_EN
    rev_cfg    = start ? bus.reverse : reverse_q;
`else
    rev_cfg    = 1'b0;
`endif
    rows_cfg_t = STEP_W'(rows_cfg);
    step_t     = start ? '0 : t_q;
    last_t     = WR_LAT_T + STEP_W'(rows_q) - STEP_W'(1);
    step_valid = start || ((state == RUN) && (t_q <= last_t));
    lane_stall = (state == RUN) && bus.stall;
    emit       = step_valid && !lane_stall;
    wr_window  = (step_t >= WR_LAT_T) && (step_t < WR_LAT_T + rows_cfg_t);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      t_q         <= '0;
      base_q      <= '0;
      rows_q      <= '0;
      wr_active_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SKEW_RD_CONTROL_REVERSE_EN
      reverse_q   <= 1'b0;
`endif
    end else begin
      done_q      <= 1'b0;
      wr_active_q <= emit && wr_window;
      case (state)
        IDLE, FINISH: begin
          if (accept) begin
            base_q <= bus.base_addr;
            rows_q <= bus.num_rows;
`ifdef SKEW_RD_CONTROL_REVERSE_EN
            reverse_q <= bus.reverse;
`endif
            if (start) begin
              state  <= RUN;
              t_q    <= STEP_W'(1);
              busy_q <= 1'b1;
            end else begin
              state  <= FINISH;
              done_q <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (!bus.stall) begin
            if (t_q > last_t) begin
              state  <= FINISH;
              t_q    <= '0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              t_q <= t_q + STEP_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH_HEIGHT; i++) begin : g_lane
    logic [STEP_W-1:0] lag;
    assign lag = STEP_W'(lag_of(i, WIDTH_HEIGHT, rev_cfg));

    rd_lane_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .STEP_W     (STEP_W)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .step_valid (step_valid),
      .stall      (lane_stall),
      .t          (step_t),
      .lag        (lag),
      .num_rows   (rows_cfg),
      .base       (base_cfg),
      .rd_en      (rd_en_w[i]),
      .rd_addr    (rd_addr_w[i*ADDR_WIDTH +: ADDR_WIDTH])
    );
  end

  assign bus.rd_en     = rd_en_w;
  assign bus.rd_addr   = rd_addr_w;
  assign bus.wr_active = wr_active_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign fsm_state     = state;

endmodule

// File: tb/tb_skew_rd_control.sv
// Self-checking bench for skew_rd_control (4 banks, 8-bit addresses, WR_LATENCY 5).
// Cycle k's inputs are driven at its negedge; cycle k's outputs are sampled at its negedge.
module tb_skew_rd_control;
  import skew_rd_pkg::*;

  localparam int WH   = 4;
  localparam int AW   = 8;
  localparam int WRL  = 5;
  localparam int W    = WH + WH*AW + 3;
  localparam int MAXC = 300;

  logic   clk = 1'b0;
  logic   reset;
  state_t fsm_state;

  always #5 clk = ~clk;

  skew_rd_control_if #(.WIDTH_HEIGHT(WH), .ADDR_WIDTH(AW)) bus ();

  skew_rd_control #(.WIDTH_HEIGHT(WH), .ADDR_WIDTH(AW), .WR_LATENCY(WRL)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic          s_act[MAXC], s_stall[MAXC], s_rst[MAXC], s_rev[MAXC];
  logic [AW-1:0] s_base[MAXC], s_num[MAXC];
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  obs_v[MAXC];

  function automatic logic [WH-1:0] en_at(input int k);
    return obs_v[k][W-1 -: WH];
  endfunction
  function automatic logic [AW-1:0] addr_at(input int k, input int b);
    return obs_v[k][3 + b*AW +: AW];
  endfunction

  task automatic clear_sched();
    for (int k = 0; k < MAXC; k++) begin
      s_act[k] = 0; s_stall[k] = 0; s_rst[k] = 0; s_rev[k] = 0;
      s_base[k] = '0; s_num[k] = '0;
    end
  endtask

  task automatic drive_idle();
    bus.active = 0; bus.stall = 0; bus.base_addr = '0; bus.num_rows = '0;
`ifdef SKEW_RD_CONTROL_REVERSE_EN
    bus.reverse = 0;
`endif
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1; drive_idle();
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  // Reference model: replays the schedule through the behaviour rules, one
  // expected output word per cycle 1..n.
  task automatic model_build(input int n);
    bit            xfer, show;
    int            t, lag;
    logic [AW-1:0] lb, ln;
    bit            lr;
    logic [AW-1:0] addr[WH];
    logic [WH*AW-1:0] ap;
    logic [WH-1:0] en;
    logic          wr, busy, done;
    xfer = 0; t = 0; lb = '0; ln = '0; lr = 0; busy = 0;
    for (int i = 0; i < WH; i++) addr[i] = '0;
    exp_q.delete();
    for (int k = 1; k <= n; k++) begin
      en = '0; wr = 0; done = 0; show = 0;
      if (s_rst[k-1]) begin
        xfer = 0; busy = 0; t = 0;
        for (int i = 0; i < WH; i++) addr[i] = '0;
      end else begin
        if (!xfer && s_act[k-1]) begin
          lb = s_base[k-1]; ln = s_num[k-1]; lr = s_rev[k-1];
          if (ln == 0) done = 1;
          else begin xfer = 1; t = 0; show = 1; end
        end else if (xfer && !s_stall[k-1]) begin
          if (t == WRL + int'(ln)) begin xfer = 0; done = 1; end
          else show = 1;
        end
        if (show) begin
          for (int i = 0; i < WH; i++) begin
            lag = lr ? (WH - 1 - i) : i;
            if (t >= lag && t < lag + int'(ln)) begin
              en[i]   = 1'b1;
              addr[i] = lb + AW'(t - lag);
            end
          end
          wr = (t >= WRL) && (t < WRL + int'(ln));
          t++;
        end
        busy = xfer;
      end
      for (int i = 0; i < WH; i++) ap[i*AW +: AW] = addr[i];
      exp_q.push_back({en, ap, wr, busy, done});
    end
  endtask

  task automatic run_sched(input int n);
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      if (k > 0) obs_v[k] = {bus.rd_en, bus.rd_addr, bus.wr_active, bus.busy, bus.done};
      if (k < n) begin
        reset = s_rst[k]; bus.active = s_act[k]; bus.stall = s_stall[k];
        bus.base_addr = s_base[k]; bus.num_rows = s_num[k];
`ifdef SKEW_RD_CONTROL_REVERSE_EN
        bus.reverse = s_rev[k];
`endif
      end else begin
        reset = 0; drive_idle();
      end
    end
  endtask

  task automatic start_at(input int k, input logic [AW-1:0] b, input logic [AW-1:0] n);
    s_act[k] = 1; s_base[k] = b; s_num[k] = n;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1; bus.active = 1; bus.base_addr = 8'h10; bus.num_rows = 8'd3; bus.stall = 0;
`ifdef SKEW_RD_CONTROL_REVERSE_EN
    bus.reverse = 0;
`endif
    @(negedge clk);
    vectors++;
    if ({bus.rd_en, bus.rd_addr, bus.wr_active, bus.busy, bus.done} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0", {bus.rd_en, bus.rd_addr, bus.wr_active, bus.busy, bus.done});
    end
    vectors++;
    if (fsm_state !== IDLE) begin
      miscompares++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, IDLE);
    end
    @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_beats_active: busy got %b expected 0", bus.busy);
    end
    reset = 0; drive_idle();
    @(negedge clk);
    vectors++;
    if ({bus.rd_en, bus.busy, bus.done} !== '0) begin
      miscompares++; $display("FAIL reset_release: got %h expected 0", {bus.rd_en, bus.busy, bus.done});
    end
  endtask

  task automatic test_basic();
    logic [WH-1:0] tbl[6];
    logic [W-1:0]  e;
    tbl = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
    clear_sched(); start_at(0, 8'h10, 8'd3);
    apply_reset(); model_build(12); run_sched(12);
    for (int k = 1; k <= 12; k++) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_v[k] !== e) begin
        miscompares++; $display("FAIL basic_trace cycle %0d: got %h expected %h", k, obs_v[k], e);
      end
    end
    for (int j = 0; j < 6; j++) begin
      vectors++;
      if (en_at(j+1) !== tbl[j]) begin
        miscompares++; $display("FAIL basic_rd_en cycle %0d: got %b expected %b", j+1, en_at(j+1), tbl[j]);
      end
    end
    vectors++;
    if (addr_at(2, 0) !== 8'h11 || addr_at(2, 1) !== 8'h10) begin
      miscompares++; $display("FAIL basic_addr cycle 2: got %h/%h expected 11/10", addr_at(2, 0), addr_at(2, 1));
    end
    for (int k = 1; k <= 12; k++) begin
      vectors++;
      if (obs_v[k][2] !== (k >= 6 && k <= 8) || obs_v[k][0] !== (k == 9)) begin
        miscompares++; $display("FAIL basic_wr_done cycle %0d: got wr=%b done=%b", k, obs_v[k][2], obs_v[k][0]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] a[4];
    logic [W-1:0]  e;
    a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    clear_sched(); start_at(0, 8'hFE, 8'd4);
    apply_reset(); model_build(12); run_sched(12);
    for (int k = 1; k <= 12; k++) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_v[k] !== e) begin
        miscompares++; $display("FAIL wrap_trace cycle %0d: got %h expected %h", k, obs_v[k], e);
      end
    end
    for (int j = 0; j < 4; j++) begin
      vectors++;
      if (addr_at(j+1, 0) !== a[j] || en_at(j+1)[0] !== 1'b1 ||
          addr_at(j+4, 3) !== a[j] || en_at(j+4)[3] !== 1'b1) begin
        miscompares++;
        $display("FAIL wrap_addr step %0d: got b0=%h b3=%h expected %h", j, addr_at(j+1, 0), addr_at(j+4, 3), a[j]);
      end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] e;
    clear_sched(); start_at(0, 8'h10, 8'd3);
    s_stall[2] = 1; s_stall[3] = 1;
    apply_reset(); model_build(13); run_sched(13);
    for (int k = 1; k <= 13; k++) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_v[k] !== e) begin
        miscompares++; $display("FAIL stall_trace cycle %0d: got %h expected %h", k, obs_v[k], e);
      end
    end
    vectors++;
    if (en_at(3) !== 4'b0000 || en_at(4) !== 4'b0000 || en_at(5) !== 4'b0111) begin
      miscompares++; $display("FAIL stall_rd_en: got %b %b %b expected 0000 0000 0111", en_at(3), en_at(4), en_at(5));
    end
    for (int k = 1; k <= 13; k++) begin
      vectors++;
      if (obs_v[k][0] !== (k == 11)) begin
        miscompares++; $display("FAIL stall_done cycle %0d: got %b", k, obs_v[k][0]);
      end
    end
  endtask

  task automatic test_zero_rows();
    clear_sched(); start_at(0, 8'h33, 8'd0);
    apply_reset(); model_build(4); run_sched(4);
    exp_q.delete();
    for (int k = 1; k <= 4; k++) begin
      vectors++;
      if (en_at(k) !== '0 || obs_v[k][1] !== 1'b0 || obs_v[k][0] !== (k == 1)) begin
        miscompares++;
        $display("FAIL zero_rows cycle %0d: got en=%b busy=%b done=%b", k, en_at(k), obs_v[k][1], obs_v[k][0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [WH-1:0] tbl[6];
    logic [W-1:0]  e;
    tbl = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
    clear_sched(); start_at(0, 8'h10, 8'd3); s_rst[3] = 1; start_at(6, 8'h10, 8'd3);
    apply_reset(); model_build(18); run_sched(18);
    for (int k = 1; k <= 18; k++) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_v[k] !== e) begin
        miscompares++; $display("FAIL reset_mid_trace cycle %0d: got %h expected %h", k, obs_v[k], e);
      end
    end
    vectors++;
    if (obs_v[4] !== '0) begin
      miscompares++; $display("FAIL reset_mid_clear: got %h expected 0", obs_v[4]);
    end
    for (int j = 0; j < 6; j++) begin
      vectors++;
      if (en_at(j+7) !== tbl[j]) begin
        miscompares++; $display("FAIL reset_mid_restart cycle %0d: got %b expected %b", j+7, en_at(j+7), tbl[j]);
      end
    end
    for (int k = 1; k <= 18; k++) begin
      vectors++;
      if (obs_v[k][0] !== (k == 15)) begin
        miscompares++; $display("FAIL reset_mid_done cycle %0d: got %b", k, obs_v[k][0]);
      end
    end
  endtask

  task automatic test_repulse();
    logic [WH-1:0] tbl[6];
    logic [W-1:0]  e;
    tbl = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
    clear_sched(); start_at(0, 8'h10, 8'd3); start_at(2, 8'h77, 8'd9); start_at(5, 8'h20, 8'd1);
    apply_reset(); model_build(12); run_sched(12);
    for (int k = 1; k <= 12; k++) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_v[k] !== e) begin
        miscompares++; $display("FAIL repulse_trace cycle %0d: got %h expected %h", k, obs_v[k], e);
      end
    end
    for (int j = 0; j < 6; j++) begin
      vectors++;
      if (en_at(j+1) !== tbl[j] || obs_v[j+1][0] !== 1'b0) begin
        miscompares++; $display("FAIL repulse_rd_en cycle %0d: got %b expected %b", j+1, en_at(j+1), tbl[j]);
      end
    end
    vectors++;
    if (addr_at(3, 0) !== 8'h12 || obs_v[9][0] !== 1'b1) begin
      miscompares++; $display("FAIL repulse_addr_done: got addr=%h done9=%b expected 12/1", addr_at(3, 0), obs_v[9][0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e;
    clear_sched(); start_at(0, 8'h10, 8'd3); start_at(9, 8'h40, 8'd2);
    apply_reset(); model_build(20); run_sched(20);
    for (int k = 1; k <= 20; k++) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_v[k] !== e) begin
        miscompares++; $display("FAIL b2b_trace cycle %0d: got %h expected %h", k, obs_v[k], e);
      end
    end
    vectors++;
    if (en_at(10) !== 4'b0001 || addr_at(10, 0) !== 8'h40 || obs_v[10][1] !== 1'b1 || obs_v[17][0] !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_restart: got en=%b addr=%h busy=%b done17=%b", en_at(10), addr_at(10, 0), obs_v[10][1], obs_v[17][0]);
    end
  endtask

  task automatic test_max_rows();
    logic [W-1:0] e;
    int n;
    n = WRL + 255 + 4;
    clear_sched(); start_at(0, AW'($urandom_range(0, 255)), 8'd255);
    apply_reset(); model_build(n); run_sched(n);
    for (int k = 1; k <= n; k++) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_v[k] !== e) begin
        miscompares++; $display("FAIL max_rows_trace cycle %0d: got %h expected %h", k, obs_v[k], e);
      end
    end
    vectors++;
    if (obs_v[261][0] !== 1'b1 || obs_v[260][2] !== 1'b1 || obs_v[261][2] !== 1'b0) begin
      miscompares++; $display("FAIL max_rows_end: got done=%b wr260=%b wr261=%b", obs_v[261][0], obs_v[260][2], obs_v[261][2]);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    for (int it = 0; it < 15; it++) begin
      clear_sched();
      for (int k = 0; k < 40; k++) begin
        s_act[k]   = (k == 0) || ($urandom_range(0, 5) == 0);
        s_base[k]  = AW'($urandom_range(0, 255));
        s_num[k]   = AW'($urandom_range(0, 6));
        s_stall[k] = ($urandom_range(0, 3) == 0);
        s_rst[k]   = (k > 0) && ($urandom_range(0, 39) == 0);
`ifdef SKEW_RD_CONTROL_REVERSE_EN
        s_rev[k]   = $urandom_range(0, 1) == 1;
`endif
      end
      apply_reset(); model_build(40); run_sched(40);
      for (int k = 1; k <= 40; k++) begin
        e = exp_q.pop_front(); vectors++;
        if (obs_v[k] !== e) begin
          miscompares++; $display("FAIL random_trace iter %0d cycle %0d: got %h expected %h", it, k, obs_v[k], e);
        end
      end
    end
  endtask

  initial begin
    reset = 1;
    drive_idle();
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_zero_rows();
    test_reset_mid();
    test_repulse();
    test_back_to_back();
    test_max_rows();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
